// File: rtl/dice_round_ctrl_if.sv
// Signal bundle between dice_round_ctrl and its surroundings.
// The DUT side is the slave modport; the button driver/display side is master.
// There is no valid/ready handshake: btn1/btn2 are raw asynchronous levels,
// and every output is a registered level except round_done, which is a
// one-cycle pulse. state_dbg mirrors the round FSM state for observation.
interface dice_round_ctrl_if;
  logic       btn1;
  logic       btn2;
  logic [2:0] dice1;
  logic [2:0] dice2;
  logic       rolled1;
  logic       rolled2;
  logic       show_active;
  logic       round_done;
  logic [1:0] state_dbg;

  modport master (
    output btn1, btn2,
    input  dice1, dice2, rolled1, rolled2, show_active, round_done, state_dbg
  );

  modport slave (
    input  btn1, btn2,
    output dice1, dice2, rolled1, rolled2, show_active, round_done, state_dbg
  );
endinterface

// File: rtl/dice_round_ctrl.sv
// Two-player dice round sequencer.
// Synchronises both roll buttons, samples a free-running 1..6 counter on each
// player's first press of the round, holds the result in SHOW and then clears.
// Optional feature macro: DICE_AUTO_CLEAR_EN
//   defined   : SHOW clears itself after SHOW_CYCLES cycles, presses ignored.
//   undefined : SHOW holds until any press, which is consumed by the clear.
module dice_round_ctrl #(
  parameter int SHOW_CYCLES = 10_000_000
) (
  input logic              clk,
  input logic              rst,
  dice_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALF = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam logic [23:0] TIMER_INIT = 24'(SHOW_CYCLES - 1);

  // bit 0 belongs to player 1, bit 1 to player 2
  logic [1:0]  s1_q, s1_d;
  logic [1:0]  s2_q, s2_d;
  logic [1:0]  prev_q, prev_d;
  logic [1:0]  press;

  logic [2:0]  cnt_q, cnt_d;
  // The timer is reloaded on every SHOW entry in both builds; only the
  // auto-clear build consults it to leave SHOW.
  logic [23:0] timer_q, timer_d;

  state_t      state_q, state_d;
  logic [2:0]  dice1_q, dice1_d;
  logic [2:0]  dice2_q, dice2_d;
  logic        rolled1_q, rolled1_d;
  logic        rolled2_q, rolled2_d;
  logic        show_q, show_d;
  logic        done_q, done_d;
  logic        show_exit;

  // Synchroniser chain and edge detector; press is a single-cycle rise of s2.
  always_comb begin
    s1_d   = {bus.btn2, bus.btn1};
    s2_d   = s1_q;
    prev_d = s2_q;
    press  = s2_q & ~prev_q;
  end

  // Free-running die face counter 1..6, never 0 or 7.
  always_comb begin
    cnt_d = (cnt_q == 3'd6) ? 3'd1 : cnt_q + 3'd1;
  end

  // SHOW exit condition depends on the build flavour.
  always_comb begin
    show_exit = 1'b0;
`ifdef DICE_AUTO_CLEAR_EN
    show_exit = (timer_q == 24'd0);
`else
    show_exit = |press;
`endif
  end

  // Round FSM next-state and registered output values.
  always_comb begin
    state_d   = state_q;
    dice1_d   = dice1_q;
    dice2_d   = dice2_q;
    rolled1_d = rolled1_q;
    rolled2_d = rolled2_q;
    show_d    = show_q;
    done_d    = 1'b0;
    timer_d   = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (press[0]) begin
          dice1_d   = cnt_q;
          rolled1_d = 1'b1;
        end
        if (press[1]) begin
          dice2_d   = cnt_q;
          rolled2_d = 1'b1;
        end
        if (&press) begin
          state_d = ST_SHOW;
          show_d  = 1'b1;
          timer_d = TIMER_INIT;
        end else if (|press) begin
          state_d = ST_HALF;
        end
      end
      ST_HALF: begin
        // Only the player who has not rolled yet may roll; no rerolls.
        if (!rolled1_q && press[0]) begin
          dice1_d   = cnt_q;
          rolled1_d = 1'b1;
          state_d   = ST_SHOW;
          show_d    = 1'b1;
          timer_d   = TIMER_INIT;
        end else if (!rolled2_q && press[1]) begin
          dice2_d   = cnt_q;
          rolled2_d = 1'b1;
          state_d   = ST_SHOW;
          show_d    = 1'b1;
          timer_d   = TIMER_INIT;
        end
      end
      ST_SHOW: begin
        if (show_exit) begin
          state_d   = ST_IDLE;
          dice1_d   = 3'd0;
          dice2_d   = 3'd0;
          rolled1_d = 1'b0;
          rolled2_d = 1'b0;
          show_d    = 1'b0;
          done_d    = 1'b1;
        end else if (timer_q != 24'd0) begin
          timer_d = timer_q - 24'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; synchroniser flops reset high so a held button is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      prev_q    <= 2'b11;
      cnt_q     <= 3'd1;
      timer_q   <= 24'd0;
      state_q   <= ST_IDLE;
      dice1_q   <= 3'd0;
      dice2_q   <= 3'd0;
      rolled1_q <= 1'b0;
      rolled2_q <= 1'b0;
      show_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
      dice1_q   <= dice1_d;
      dice2_q   <= dice2_d;
      rolled1_q <= rolled1_d;
      rolled2_q <= rolled2_d;
      show_q    <= show_d;
      done_q    <= done_d;
    end
  end

  assign bus.dice1       = dice1_q;
  assign bus.dice2       = dice2_q;
  assign bus.rolled1     = rolled1_q;
  assign bus.rolled2     = rolled2_q;
  assign bus.show_active = show_q;
  assign bus.round_done  = done_q;
  assign bus.state_dbg   = state_q;

endmodule
